// File: rtl/poli_pkg.sv
// Shared definitions for the polynomial-datapath arbiter: state encoding,
// default operand width and the watchdog counter sizing helper.
package poli_pkg;

  localparam logic [1:0] ST_OCIOSO  = 2'd0;
  localparam logic [1:0] ST_DISPARO = 2'd1;
  localparam logic [1:0] ST_ESPERA  = 2'd2;
  localparam logic [1:0] ST_ENTREGA = 2'd3;

  typedef enum logic [1:0] {
    OCIOSO  = ST_OCIOSO,
    DISPARO = ST_DISPARO,
    ESPERA  = ST_ESPERA,
    ENTREGA = ST_ENTREGA
  } estado_t;

  localparam int LARGURA_PADRAO = 16;

  // Bits needed to count 0..ciclos inclusive.
  function automatic int largura_contador(input int ciclos);
    return (ciclos < 2) ? 1 : $clog2(ciclos + 1);
  endfunction

endpackage

// File: rtl/rr_prioridade.sv
// Combinational round-robin picker: first active request at or above ptr,
// wrapping, returned both one-hot and as an index.
module rr_prioridade #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] vencedor,
  output logic [PW-1:0]    indice,
  output logic             valido
);

  logic [PW-1:0] cand [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand[gi] = PW'((32'(ptr) + 32'(gi)) % 32'(N_REQ));
  end

  // Scan from the farthest candidate down so the one closest to ptr wins.
  always_comb begin
    vencedor = '0;
    indice   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        vencedor          = '0;
        vencedor[cand[k]] = 1'b1;
        indice            = cand[k];
      end
    end
  end

  assign valido = |req;

endmodule

// File: rtl/arbitro_polinomio.sv
// Round-robin sequencer sharing one polynomial datapath among N_REQ requesters.
// Optional watchdog abort in ESPERA enabled by defining ARB_TIMEOUT_EN.
module arbitro_polinomio
  import poli_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int LARGURA        = LARGURA_PADRAO,
  parameter int TIMEOUT_CICLOS = 64
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LARGURA-1:0] x_in,
  input  logic [N_REQ*LARGURA-1:0] a_in,
  input  logic [N_REQ*LARGURA-1:0] b_in,
  input  logic [N_REQ*LARGURA-1:0] c_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         feito,
  output logic [LARGURA-1:0]       resultado_out,
  output logic                     overflow_out,
  output logic                     erro_out,
  output logic                     dp_inicio,
  output logic [LARGURA-1:0]       dp_x,
  output logic [LARGURA-1:0]       dp_a,
  output logic [LARGURA-1:0]       dp_b,
  output logic [LARGURA-1:0]       dp_c,
  input  logic [LARGURA-1:0]       dp_resultado,
  input  logic                     dp_pronto,
  input  logic                     dp_overflow
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CICLOS < 1) begin : g_param_invalido
    $error("arbitro_polinomio: N_REQ must be 2..8 and TIMEOUT_CICLOS >= 1");
  end

  estado_t            estado_reg, estado_next;
  logic               primeiro_reg;
  logic [PW-1:0]      ptr_reg, idx_reg, ptr_prox;
  logic [N_REQ-1:0]   gnt_reg;
  logic [LARGURA-1:0] x_reg, a_reg, b_reg, c_reg, resultado_reg;
  logic               overflow_reg;
  logic [N_REQ-1:0]   venc;
  logic [PW-1:0]      venc_idx;
  logic               algum;
  logic               aceita_pronto, expirou;

  logic [LARGURA-1:0] x_arr [N_REQ];
  logic [LARGURA-1:0] a_arr [N_REQ];
  logic [LARGURA-1:0] b_arr [N_REQ];
  logic [LARGURA-1:0] c_arr [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_fatias
    assign x_arr[gi] = x_in[gi*LARGURA +: LARGURA];
    assign a_arr[gi] = a_in[gi*LARGURA +: LARGURA];
    assign b_arr[gi] = b_in[gi*LARGURA +: LARGURA];
    assign c_arr[gi] = c_in[gi*LARGURA +: LARGURA];
    assign feito[gi] = (estado_reg == ENTREGA) && (idx_reg == PW'(gi));
  end

  rr_prioridade #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req      (req),
    .ptr      (ptr_reg),
    .vencedor (venc),
    .indice   (venc_idx),
    .valido   (algum)
  );

  // The first ESPERA cycle may still see pronto left over from a previous job.
  assign aceita_pronto = (estado_reg == ESPERA) && !primeiro_reg && dp_pronto;
  assign ptr_prox      = (idx_reg == PW'(N_REQ - 1)) ? '0 : idx_reg + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = largura_contador(TIMEOUT_CICLOS);
  logic [CW-1:0] cnt_reg;
  logic          erro_reg;

  always_ff @(posedge ck) begin
    if (rst || estado_reg != ESPERA) cnt_reg <= '0;
    else                             cnt_reg <= cnt_reg + 1'b1;
  end

  assign expirou = (estado_reg == ESPERA) && !aceita_pronto &&
                   (cnt_reg == CW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge ck) begin
    if (rst)                erro_reg <= 1'b0;
    else if (aceita_pronto) erro_reg <= 1'b0;
    else if (expirou)       erro_reg <= 1'b1;
  end

  assign erro_out = erro_reg;
`else
  assign expirou  = 1'b0;
  assign erro_out = 1'b0;
`endif

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      OCIOSO:  if (algum) estado_next = DISPARO;
      DISPARO: estado_next = ESPERA;
      ESPERA:  if (aceita_pronto || expirou) estado_next = ENTREGA;
      ENTREGA: estado_next = OCIOSO;
      default: estado_next = OCIOSO;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      estado_reg    <= OCIOSO;
      primeiro_reg  <= 1'b0;
      ptr_reg       <= '0;
      idx_reg       <= '0;
      gnt_reg       <= '0;
      x_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      resultado_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      primeiro_reg <= (estado_reg == DISPARO);
      if (estado_reg == OCIOSO && algum) begin
        gnt_reg <= venc;
        idx_reg <= venc_idx;
        x_reg   <= x_arr[venc_idx];
        a_reg   <= a_arr[venc_idx];
        b_reg   <= b_arr[venc_idx];
        c_reg   <= c_arr[venc_idx];
      end
      if (aceita_pronto) begin
        resultado_reg <= dp_resultado;
        overflow_reg  <= dp_overflow;
        gnt_reg       <= '0;
      end else if (expirou) begin
        resultado_reg <= '0;
        overflow_reg  <= 1'b0;
        gnt_reg       <= '0;
      end
      if (estado_reg == ENTREGA) ptr_reg <= ptr_prox;
    end
  end

  assign gnt           = gnt_reg;
  assign dp_inicio     = (estado_reg == DISPARO);
  assign dp_x          = x_reg;
  assign dp_a          = a_reg;
  assign dp_b          = b_reg;
  assign dp_c          = c_reg;
  assign resultado_out = resultado_reg;
  assign overflow_out  = overflow_reg;

endmodule

// File: tb/tb_arbitro_polinomio.sv
// Scoreboard bench for arbitro_polinomio with a datapath model answering
// 5 cycles after inicio; watchdog test runs only when ARB_TIMEOUT_EN is defined.
module tb_arbitro_polinomio;

  localparam int N = 4;
  localparam int L = 16;

  logic           ck = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*L-1:0] x_in = '0, a_in = '0, b_in = '0, c_in = '0;
  logic [N-1:0]   gnt, feito;
  logic [L-1:0]   resultado_out, dp_x, dp_a, dp_b, dp_c;
  logic           overflow_out, erro_out, dp_inicio;
  logic [L-1:0]   dp_resultado = '0;
  logic           dp_pronto = 1'b0;
  logic           dp_overflow = 1'b0;

  arbitro_polinomio #(.N_REQ(N), .LARGURA(L), .TIMEOUT_CICLOS(64)) dut (
    .ck(ck), .rst(rst), .req(req),
    .x_in(x_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .feito(feito), .resultado_out(resultado_out),
    .overflow_out(overflow_out), .erro_out(erro_out),
    .dp_inicio(dp_inicio), .dp_x(dp_x), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_resultado(dp_resultado), .dp_pronto(dp_pronto), .dp_overflow(dp_overflow)
  );

  always #5 ck = ~ck;

  typedef struct {
    int         idx;
    logic [L-1:0] x, a, b, c, res;
    logic       ovf, erro;
    int         lat;
  } esp_t;

  esp_t fila[$];
  int   vetores = 0;
  int   erros   = 0;
  int   ciclo   = 0;
  int   t_inicio = 0;
  int   cnt_dp  = 0;
  bit   travar  = 0;
  bit   pronto_fixo = 0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, esp, ciclo);
    end
  endtask

  always @(posedge ck) ciclo++;

  // Datapath model plus output monitor; one process so pops and lookups never race.
  always @(negedge ck) begin
    if (rst) begin
      cnt_dp    = 0;
      dp_pronto = 1'b0;
    end else begin
      if (!pronto_fixo && dp_pronto) dp_pronto = 1'b0;
      if (dp_inicio) begin
        if (fila.size() == 0) begin
          verifica("inicio_unexpected", 32'(dp_inicio), 32'd0);
        end else begin
          verifica("gnt", 32'(gnt), 32'(1) << fila[0].idx);
          verifica("dp_x", 32'(dp_x), 32'(fila[0].x));
          verifica("dp_a", 32'(dp_a), 32'(fila[0].a));
          verifica("dp_b", 32'(dp_b), 32'(fila[0].b));
          verifica("dp_c", 32'(dp_c), 32'(fila[0].c));
          dp_resultado = fila[0].res;
          dp_overflow  = fila[0].ovf;
          $display("inicio   cycle=%0d gnt=%b x=%0d", ciclo, gnt, dp_x);
        end
        t_inicio = ciclo;
        cnt_dp   = 5;
      end else if (cnt_dp > 0) begin
        cnt_dp--;
        if (cnt_dp == 0 && !travar) dp_pronto = 1'b1;
      end
      if (pronto_fixo && !travar) dp_pronto = 1'b1;
      if (feito != '0) begin
        if (fila.size() == 0) begin
          verifica("feito_unexpected", 32'(feito), 32'd0);
        end else begin
          esp_t e;
          e = fila.pop_front();
          verifica("feito", 32'(feito), 32'(1) << e.idx);
          verifica("resultado", 32'(resultado_out), 32'(e.res));
          verifica("overflow", 32'(overflow_out), 32'(e.ovf));
          verifica("erro", 32'(erro_out), 32'(e.erro));
          verifica("latencia", 32'(ciclo - t_inicio), 32'(e.lat));
          $display("feito    cycle=%0d feito=%b res=%h ovf=%b erro=%b",
                   ciclo, feito, resultado_out, overflow_out, erro_out);
        end
      end
    end
  end

  task automatic empurra(input int idx, input logic [L-1:0] x, input logic [L-1:0] a,
                         input logic [L-1:0] b, input logic [L-1:0] c,
                         input logic [L-1:0] res, input logic ovf, input logic erro,
                         input int lat);
    esp_t e;
    e.idx = idx; e.x = x; e.a = a; e.b = b; e.c = c;
    e.res = res; e.ovf = ovf; e.erro = erro; e.lat = lat;
    fila.push_back(e);
  endtask

  task automatic operandos(input int i, input logic [L-1:0] x, input logic [L-1:0] a,
                           input logic [L-1:0] b, input logic [L-1:0] c);
    x_in[i*L +: L] = x;
    a_in[i*L +: L] = a;
    b_in[i*L +: L] = b;
    c_in[i*L +: L] = c;
  endtask

  // Returns just after the monitor has drained the queue, i.e. inside ENTREGA.
  task automatic espera_fila(input int limite);
    int n;
    n = 0;
    while (fila.size() != 0 && n < limite) begin
      @(negedge ck); #1;
      n++;
    end
    if (fila.size() != 0) begin
      verifica("wait_timeout", 32'(fila.size()), 32'd0);
      fila.delete();
    end
  endtask

  task automatic espera_inicio(input int limite);
    int n;
    n = 0;
    while (dp_inicio !== 1'b1 && n < limite) begin
      @(negedge ck); #1;
      n++;
    end
    verifica("inicio_seen", 32'(dp_inicio), 32'd1);
  endtask

  task automatic aplica_reset(input int ciclos);
    rst = 1'b1;
    req = '0;
    repeat (ciclos) @(posedge ck);
    @(negedge ck); #1;
    verifica("rst_gnt", 32'(gnt), 32'd0);
    verifica("rst_feito", 32'(feito), 32'd0);
    verifica("rst_inicio", 32'(dp_inicio), 32'd0);
    verifica("rst_dp_x", 32'(dp_x), 32'd0);
    verifica("rst_dp_c", 32'(dp_c), 32'd0);
    verifica("rst_resultado", 32'(resultado_out), 32'd0);
    verifica("rst_overflow", 32'(overflow_out), 32'd0);
    verifica("rst_erro", 32'(erro_out), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Reset
    aplica_reset(2);
    verifica("rst_dp_a", 32'(dp_a), 32'd0);
    verifica("rst_dp_b", 32'(dp_b), 32'd0);

    // Single request on requester 0
    operandos(0, 16'd23, 16'd38, 16'd333, 16'd4902);
    empurra(0, 16'd23, 16'd38, 16'd333, 16'd4902, 16'd32663, 1'b0, 1'b0, 6);
    req = 4'b0001;
    espera_fila(40);
    req = '0;
    repeat (4) @(negedge ck);
    verifica("resultado_hold", 32'(resultado_out), 32'd32663);
    verifica("idle_gnt", 32'(gnt), 32'd0);

    // Contention from a fresh pointer: strict 0,1,2,3 rotation
    aplica_reset(1);
    for (int i = 0; i < N; i++)
      operandos(i, 16'(100 + i), 16'(200 + i), 16'(300 + i), 16'(400 + i));
    for (int j = 0; j < 8; j++)
      empurra(j % N, 16'(100 + j % N), 16'(200 + j % N), 16'(300 + j % N),
              16'(400 + j % N), 16'(1000 + j), 1'b0, 1'b0, 6);
    req = 4'b1111;
    espera_fila(200);
    req = '0;

    // Overflow pass-through, held until the next delivery
    operandos(2, 16'd7, 16'd8, 16'd9, 16'd10);
    empurra(2, 16'd7, 16'd8, 16'd9, 16'd10, 16'hFFFF, 1'b1, 1'b0, 6);
    req = 4'b0100;
    espera_fila(40);
    req = '0;
    repeat (6) @(negedge ck);
    verifica("ovf_hold", 32'(overflow_out), 32'd1);
    verifica("ovf_res_hold", 32'(resultado_out), 32'hFFFF);
    operandos(1, 16'd1, 16'd2, 16'd3, 16'd4);
    empurra(1, 16'd1, 16'd2, 16'd3, 16'd4, 16'h1234, 1'b0, 1'b0, 6);
    req = 4'b0010;
    espera_fila(40);
    req = '0;

    // Requester drops req and changes X mid-ESPERA
    @(negedge ck);
    operandos(3, 16'd777, 16'd55, 16'd66, 16'd77);
    empurra(3, 16'd777, 16'd55, 16'd66, 16'd77, 16'd4242, 1'b0, 1'b0, 6);
    req = 4'b1000;
    espera_inicio(10);
    @(negedge ck); @(negedge ck);
    req = '0;
    x_in[3*L +: L] = 16'd999;
    @(negedge ck); #1;
    verifica("dp_x_frozen", 32'(dp_x), 32'd777);
    espera_fila(40);

    // Reset during ESPERA aborts silently
    @(negedge ck);
    operandos(0, 16'd5, 16'd6, 16'd7, 16'd8);
    empurra(0, 16'd5, 16'd6, 16'd7, 16'd8, 16'd99, 1'b0, 1'b0, 6);
    req = 4'b0001;
    espera_inicio(10);
    @(negedge ck); @(negedge ck);
    fila.delete();
    aplica_reset(1);
    repeat (12) @(negedge ck);
    verifica("abort_idle_gnt", 32'(gnt), 32'd0);

    // Stale pronto held high: first ESPERA cycle must ignore it; sole requester re-granted
    pronto_fixo = 1;
    operandos(0, 16'd11, 16'd12, 16'd13, 16'd14);
    empurra(0, 16'd11, 16'd12, 16'd13, 16'd14, 16'h0ABC, 1'b0, 1'b0, 3);
    empurra(0, 16'd11, 16'd12, 16'd13, 16'd14, 16'h0ABC, 1'b0, 1'b0, 3);
    req = 4'b0001;
    espera_fila(40);
    req = '0;
    pronto_fixo = 0;
    repeat (8) @(negedge ck);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: datapath never answers
    travar = 1;
    operandos(1, 16'd21, 16'd22, 16'd23, 16'd24);
    empurra(1, 16'd21, 16'd22, 16'd23, 16'd24, 16'd0, 1'b0, 1'b1, 65);
    req = 4'b0010;
    espera_fila(200);
    req = '0;
    travar = 0;
    repeat (3) @(negedge ck);
    verifica("erro_hold", 32'(erro_out), 32'd1);
    operandos(2, 16'd31, 16'd32, 16'd33, 16'd34);
    empurra(2, 16'd31, 16'd32, 16'd33, 16'd34, 16'd555, 1'b0, 1'b0, 6);
    req = 4'b0100;
    espera_fila(40);
    req = '0;
`endif

    repeat (4) @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
